// File: rtl/eth_pkg.sv
// eth_pkg: shared constants, state type and word layout for the Ethernet byte packer
package eth_pkg;
  localparam int ETH_PACK_NB = 4;
  function automatic int pack_cw(input int nb);
    return $clog2(nb) + 1;
  endfunction
  function automatic int pack_ow(input int nb);
    return 8 * nb + pack_cw(nb) + 1;
  endfunction
  typedef enum logic {FILL, DONE} pack_state_t;
  localparam int ETH_PACK_DATA_OFS = 0;
  localparam int ETH_PACK_CNT_OFS = ETH_PACK_DATA_OFS + 8 * ETH_PACK_NB;
  localparam int ETH_PACK_LAST_OFS = pack_ow(ETH_PACK_NB) - 1;
endpackage

// File: rtl/eth_pack_obuf.sv
// eth_pack_obuf: output word holder feeding the CDC FIFO write port, plus frame counter
module eth_pack_obuf
  import eth_pkg::*;
#(
  parameter int OW = pack_ow(ETH_PACK_NB),
  parameter int CNTW = 16
) (
  input  logic            wclki,
  input  logic            aclri,
  input  logic            load,
  input  logic [OW-1:0]   din,
  input  logic            fullo,
  output logic            wei,
  output logic [OW-1:0]   wdatai,
  output logic            obuf_valid,
  output logic [CNTW-1:0] frames_o
);
  assign wei = obuf_valid && !fullo;
  always_ff @(posedge wclki or posedge aclri)
    if (aclri) begin
      wdatai <= '0;
      obuf_valid <= 1'b0;
      frames_o <= '0;
    end else begin
      if (load) begin
        wdatai <= din;
        obuf_valid <= 1'b1;
      end else if (wei) obuf_valid <= 1'b0;
      if (wei && wdatai[OW-1]) frames_o <= frames_o + CNTW'(1);
    end
endmodule

// File: rtl/eth_byte_packer.sv
// eth_byte_packer: packs a framed byte stream into tagged words for the CDC FIFO write side
module eth_byte_packer
  import eth_pkg::*;
#(
  parameter int NB = ETH_PACK_NB,
  parameter int CNTW = 16,
  localparam int CW = pack_cw(NB),
  localparam int OW = pack_ow(NB)
) (
  input  logic            aclri,
  input  logic            wclki,
  input  logic            s_tvalid,
  input  logic [7:0]      s_tdata,
  input  logic            s_tlast,
  output logic            s_tready,
  input  logic            s_tabort,
  output logic            wei,
  output logic [OW-1:0]   wdatai,
  input  logic            fullo,
  output logic [CNTW-1:0] frames_o,
  output logic [CNTW-1:0] aborts_o
);
  localparam int IW = $clog2(NB);
  pack_state_t state, state_n;
  logic [IW-1:0] idx;
  logic [8*NB-1:0] acc_data, base;
  logic [CW-1:0] acc_cnt;
  logic acc_last, accept, xfer, comp, obuf_valid;
  assign accept = s_tvalid && s_tready;
  assign comp = accept && !s_tabort && (s_tlast || idx == IW'(NB - 1));
  // a byte accepted during the transfer cycle lands in a freshly cleared accumulator
  assign base = xfer ? '0 : acc_data;
  always_ff @(posedge wclki or posedge aclri)
    if (aclri) state <= FILL;
    else state <= state_n;
  always_comb state_n = comp ? DONE : (state == FILL || xfer) ? FILL : state;
  always_comb begin
    xfer = state == DONE && (!obuf_valid || wei);
    s_tready = state == FILL || xfer;
  end
  always_ff @(posedge wclki or posedge aclri)
    if (aclri) begin
      acc_data <= '0;
      idx <= '0;
      acc_cnt <= '0;
      acc_last <= 1'b0;
      aborts_o <= '0;
    end else if (accept && s_tabort) begin
      acc_data <= '0;
      idx <= '0;
      aborts_o <= aborts_o + CNTW'(1);
    end else if (accept) begin
      acc_data <= base | ({{8*(NB-1){1'b0}}, s_tdata} << {idx, 3'b000});
      idx <= comp ? '0 : idx + IW'(1);
      acc_cnt <= CW'(idx) + CW'(1);
      acc_last <= s_tlast;
    end else if (xfer) acc_data <= '0;
  eth_pack_obuf #(.OW(OW), .CNTW(CNTW)) u_obuf (
    .wclki(wclki),
    .aclri(aclri),
    .load(xfer),
    .din({acc_last, acc_cnt, acc_data}),
    .fullo(fullo),
    .wei(wei),
    .wdatai(wdatai),
    .obuf_valid(obuf_valid),
    .frames_o(frames_o)
  );
endmodule

// File: tb/tb_eth_byte_packer.sv
// tb_eth_byte_packer: directed checks of packing, backpressure, abort, reset and counter wrap
module tb_eth_byte_packer;
  import eth_pkg::*;
  localparam int NB = 4;
  localparam int CNTW = 16;
  localparam int OW = pack_ow(NB);
  logic wclki = 1'b0, aclri = 1'b1, s_tvalid = 1'b0, s_tlast = 1'b0, s_tabort = 1'b0, fullo = 1'b0;
  logic [7:0] s_tdata = 8'h00;
  logic s_tready, wei;
  logic [OW-1:0] wdatai;
  logic [CNTW-1:0] frames_o, aborts_o;
  int total = 0, bad = 0, cyc = 0, t_last = 0;
  bit saw_stall;
  logic [OW-1:0] wq[$];
  int ws[$];
  eth_byte_packer #(.NB(NB), .CNTW(CNTW)) dut (
    .aclri(aclri), .wclki(wclki), .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .s_tready(s_tready), .s_tabort(s_tabort), .wei(wei), .wdatai(wdatai), .fullo(fullo),
    .frames_o(frames_o), .aborts_o(aborts_o)
  );
  always #5 wclki = ~wclki;
  always @(posedge wclki) cyc <= cyc + 1;
  always @(negedge wclki) if (wei === 1'b1) begin
    wq.push_back(wdatai);
    ws.push_back(cyc);
  end
  function automatic logic [OW-1:0] mk(input logic l, input logic [2:0] c, input logic [31:0] d);
    return {l, c, d};
  endfunction
  task send_byte(input logic [7:0] d, input logic l, input logic ab);
    int n;
    n = 0;
    s_tvalid = 1'b1; s_tdata = d; s_tlast = l; s_tabort = ab;
    forever begin
      @(negedge wclki);
      if (s_tready === 1'b1) break;
      if (fullo) saw_stall = 1'b1;
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL send_timeout: s_tready=%b for 200 cycles, required 1", s_tready);
        break;
      end
    end
    @(posedge wclki); #1;
    t_last = cyc;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tabort = 1'b0;
  endtask
  task send_frame(input logic [7:0] start, input logic [7:0] step, input int n);
    logic [7:0] b;
    b = start;
    for (int i = 0; i < n; i++) begin
      send_byte(b, i == n - 1, 1'b0);
      b = b + step;
    end
  endtask
  task settle;
    repeat (4) @(posedge wclki);
    #1;
  endtask
  task test_reset;
    repeat (2) @(posedge wclki);
    #1 aclri = 1'b0;
    total += 5;
    if (s_tready !== 1'b1) begin bad++; $display("FAIL reset_tready: got %b want 1", s_tready); end
    if (wei !== 1'b0) begin bad++; $display("FAIL reset_wei: got %b want 0", wei); end
    if (wdatai !== '0) begin bad++; $display("FAIL reset_wdatai: got %h want 0", wdatai); end
    if (frames_o !== '0) begin bad++; $display("FAIL reset_frames: got %0d want 0", frames_o); end
    if (aborts_o !== '0) begin bad++; $display("FAIL reset_aborts: got %0d want 0", aborts_o); end
  endtask
  task test_full_word;
    wq.delete(); ws.delete();
    send_frame(8'h11, 8'h11, 4);
    settle();
    total += 6;
    if (wq.size() != 1) begin bad++; $display("FAIL w4_count: got %0d want 1", wq.size()); end
    if (wq[0] !== mk(1'b1, 3'd4, 32'h44332211)) begin bad++; $display("FAIL w4_word: got %h want %h", wq[0], mk(1'b1, 3'd4, 32'h44332211)); end
    if (wq[0][ETH_PACK_LAST_OFS] !== 1'b1) begin bad++; $display("FAIL w4_last_bit: got %b want 1", wq[0][ETH_PACK_LAST_OFS]); end
    if (wq[0][ETH_PACK_CNT_OFS +: 3] !== 3'd4) begin bad++; $display("FAIL w4_cnt_field: got %0d want 4", wq[0][ETH_PACK_CNT_OFS +: 3]); end
    if (ws[0] != t_last + 1) begin bad++; $display("FAIL w4_latency: write cycle %0d want %0d", ws[0], t_last + 1); end
    if (frames_o !== 16'd1) begin bad++; $display("FAIL w4_frames: got %0d want 1", frames_o); end
  endtask
  task test_split_frame;
    wq.delete(); ws.delete();
    send_frame(8'h01, 8'h01, 6);
    settle();
    total += 4;
    if (wq.size() != 2) begin bad++; $display("FAIL w6_count: got %0d want 2", wq.size()); end
    if (wq[0] !== mk(1'b0, 3'd4, 32'h04030201)) begin bad++; $display("FAIL w6_word0: got %h want %h", wq[0], mk(1'b0, 3'd4, 32'h04030201)); end
    if (wq[1] !== mk(1'b1, 3'd2, 32'h00000605)) begin bad++; $display("FAIL w6_word1: got %h want %h", wq[1], mk(1'b1, 3'd2, 32'h00000605)); end
    if (frames_o !== 16'd2) begin bad++; $display("FAIL w6_frames: got %0d want 2", frames_o); end
  endtask
  task test_backpressure;
    wq.delete(); ws.delete();
    saw_stall = 1'b0;
    fullo = 1'b1;
    fork
      send_frame(8'h10, 8'h01, 12);
      begin
        repeat (19) @(posedge wclki);
        #1;
        total += 3;
        if (wq.size() != 0) begin bad++; $display("FAIL bp_no_write: got %0d writes want 0", wq.size()); end
        if (wei !== 1'b0) begin bad++; $display("FAIL bp_wei: got %b want 0", wei); end
        if (wdatai !== mk(1'b0, 3'd4, 32'h13121110)) begin bad++; $display("FAIL bp_hold: got %h want %h", wdatai, mk(1'b0, 3'd4, 32'h13121110)); end
        @(posedge wclki);
        #1 fullo = 1'b0;
      end
    join
    settle();
    total += 6;
    if (saw_stall !== 1'b1) begin bad++; $display("FAIL bp_stall: saw_stall=%b want 1", saw_stall); end
    if (wq.size() != 3) begin bad++; $display("FAIL bp_count: got %0d want 3", wq.size()); end
    if (wq[0] !== mk(1'b0, 3'd4, 32'h13121110)) begin bad++; $display("FAIL bp_word0: got %h want %h", wq[0], mk(1'b0, 3'd4, 32'h13121110)); end
    if (wq[1] !== mk(1'b0, 3'd4, 32'h17161514)) begin bad++; $display("FAIL bp_word1: got %h want %h", wq[1], mk(1'b0, 3'd4, 32'h17161514)); end
    if (wq[2] !== mk(1'b1, 3'd4, 32'h1b1a1918)) begin bad++; $display("FAIL bp_word2: got %h want %h", wq[2], mk(1'b1, 3'd4, 32'h1b1a1918)); end
    if (frames_o !== 16'd3) begin bad++; $display("FAIL bp_frames: got %0d want 3", frames_o); end
  endtask
  task test_abort;
    wq.delete(); ws.delete();
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b1);
    send_byte(8'hAA, 1'b1, 1'b0);
    settle();
    total += 4;
    if (aborts_o !== 16'd1) begin bad++; $display("FAIL ab_count: got %0d want 1", aborts_o); end
    if (wq.size() != 1) begin bad++; $display("FAIL ab_writes: got %0d want 1", wq.size()); end
    if (wq[0] !== mk(1'b1, 3'd1, 32'h000000AA)) begin bad++; $display("FAIL ab_word: got %h want %h", wq[0], mk(1'b1, 3'd1, 32'h000000AA)); end
    if (frames_o !== 16'd4) begin bad++; $display("FAIL ab_frames: got %0d want 4", frames_o); end
  endtask
  task test_mid_reset;
    wq.delete(); ws.delete();
    fullo = 1'b1;
    send_frame(8'h31, 8'h01, 4);
    send_byte(8'h41, 1'b0, 1'b0);
    send_byte(8'h42, 1'b0, 1'b0);
    #2 fullo = 1'b0;
    aclri = 1'b1;
    #1;
    total += 5;
    if (s_tready !== 1'b1) begin bad++; $display("FAIL rst_tready: got %b want 1", s_tready); end
    if (wei !== 1'b0) begin bad++; $display("FAIL rst_wei: got %b want 0", wei); end
    if (wdatai !== '0) begin bad++; $display("FAIL rst_wdatai: got %h want 0", wdatai); end
    if (frames_o !== '0) begin bad++; $display("FAIL rst_frames: got %0d want 0", frames_o); end
    if (aborts_o !== '0) begin bad++; $display("FAIL rst_aborts: got %0d want 0", aborts_o); end
    @(posedge wclki);
    #1 aclri = 1'b0;
    repeat (5) @(posedge wclki);
    #1;
    total++;
    if (wq.size() != 0) begin bad++; $display("FAIL rst_no_write: got %0d want 0", wq.size()); end
    send_byte(8'h5A, 1'b1, 1'b0);
    settle();
    total += 3;
    if (wq.size() != 1) begin bad++; $display("FAIL rst_writes: got %0d want 1", wq.size()); end
    if (wq[0] !== mk(1'b1, 3'd1, 32'h0000005A)) begin bad++; $display("FAIL rst_word: got %h want %h", wq[0], mk(1'b1, 3'd1, 32'h0000005A)); end
    if (frames_o !== 16'd1) begin bad++; $display("FAIL rst_frames_after: got %0d want 1", frames_o); end
  endtask
  task test_wrap;
    wq.delete(); ws.delete();
    for (int i = 0; i < 65534; i++) send_byte(8'(i), 1'b1, 1'b0);
    settle();
    total += 2;
    if (frames_o !== 16'hFFFF) begin bad++; $display("FAIL wrap_pre: got %h want ffff", frames_o); end
    if (wq.size() != 65534) begin bad++; $display("FAIL wrap_pre_count: got %0d want 65534", wq.size()); end
    send_byte(8'hFE, 1'b1, 1'b0);
    settle();
    total += 2;
    if (frames_o !== 16'h0000) begin bad++; $display("FAIL wrap_zero: got %h want 0000", frames_o); end
    if (wq[$] !== mk(1'b1, 3'd1, 32'h000000FE)) begin bad++; $display("FAIL wrap_word: got %h want %h", wq[$], mk(1'b1, 3'd1, 32'h000000FE)); end
    send_byte(8'hC3, 1'b1, 1'b0);
    settle();
    total += 3;
    if (frames_o !== 16'h0001) begin bad++; $display("FAIL wrap_after: got %h want 0001", frames_o); end
    if (wq.size() != 65536) begin bad++; $display("FAIL wrap_count: got %0d want 65536", wq.size()); end
    if (wq[$] !== mk(1'b1, 3'd1, 32'h000000C3)) begin bad++; $display("FAIL wrap_data: got %h want %h", wq[$], mk(1'b1, 3'd1, 32'h000000C3)); end
  endtask
  initial begin
    test_reset();
    test_full_word();
    test_split_frame();
    test_backpressure();
    test_abort();
    test_mid_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
